// File: rtl/ex_div_if.sv
// Interface bundling the EX-stage divider request/response signals.
// master: EX stage driving operands and control; slave: the divider.
interface ex_div_if #(
    parameter int DATA_W = 32
);
    logic                  start_i;
    logic                  annul_i;
    logic                  signed_i;
    logic [DATA_W-1:0]     dividend_i;
    logic [DATA_W-1:0]     divisor_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;
    logic                  busy_o;

    modport master (
        output start_i, annul_i, signed_i, dividend_i, divisor_i,
        input  result_o, ready_o, busy_o
    );

    modport slave (
        input  start_i, annul_i, signed_i, dividend_i, divisor_i,
        output result_o, ready_o, busy_o
    );
endinterface

// File: rtl/ex_div.sv
// ex_div: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Operands are converted to magnitudes at launch, one quotient bit is
// produced per cycle, and signs are fixed up when the result is loaded.
// result_o = {remainder, quotient}.
// Optional build macro DIV_ZERO_FAST_EN: a zero divisor skips the
// iterations and goes straight to DONE with the divide-by-zero result.
module ex_div #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic        clk,
    input  logic        rst,
    ex_div_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0] ALL_ONES  = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0] ZERO_W    = {DATA_W{1'b0}};

    // Two's-complement negation of a DATA_W value.
    function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v);
        return (~v) + DATA_W'(1);
    endfunction

    // Magnitude of an operand; only negative values of a signed op are flipped.
    function automatic logic [DATA_W-1:0] mag_w(input logic [DATA_W-1:0] v,
                                                input logic             sgn);
        return (sgn && v[DATA_W-1]) ? neg_w(v) : v;
    endfunction

    // Final {remainder, quotient} with sign correction or divide-by-zero values.
    function automatic logic [2*DATA_W-1:0] fix_result(
        input logic [DATA_W-1:0] r,
        input logic [DATA_W-1:0] q,
        input logic              qneg,
        input logic              rneg,
        input logic              dz,
        input logic [DATA_W-1:0] dvnd
    );
        logic [DATA_W-1:0] qf;
        logic [DATA_W-1:0] rf;
        if (dz) begin
            qf = ALL_ONES;
            rf = dvnd;
        end else begin
            qf = qneg ? neg_w(q) : q;
            rf = rneg ? neg_w(r) : r;
        end
        return {rf, qf};
    endfunction

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]     rem_q, rem_d;
    logic [DATA_W-1:0]     quo_q, quo_d;
    logic [DATA_W-1:0]     dvsr_q, dvsr_d;
    logic [DATA_W-1:0]     dvnd_q, dvnd_d;
    logic                  qneg_q, qneg_d;
    logic                  rneg_q, rneg_d;
    logic                  dz_q, dz_d;
    logic [2*DATA_W-1:0]   result_q, result_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;

    // One shift-subtract step: the shifted remainder needs DATA_W+1 bits.
    logic [DATA_W:0]       rem_sh_s;
    logic                  ge_s;
    logic [DATA_W-1:0]     step_rem_s;
    logic [DATA_W-1:0]     step_quo_s;

    // Datapath for a single restoring-division iteration.
    always_comb begin
        rem_sh_s   = {rem_q, quo_q[DATA_W-1]};
        ge_s       = (rem_sh_s >= {1'b0, dvsr_q});
        step_quo_s = {quo_q[DATA_W-2:0], ge_s};
        if (ge_s) begin
            // True difference is below 2^DATA_W, so modular subtraction is exact.
            step_rem_s = rem_sh_s[DATA_W-1:0] - dvsr_q;
        end else begin
            step_rem_s = rem_sh_s[DATA_W-1:0];
        end
    end

    // Next-state logic for the IDLE/BUSY/DONE controller and its datapath regs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        dvnd_d   = dvnd_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        result_d = result_q;
        ready_d  = ready_q;

        if (bus.annul_i) begin
            // A flush outranks everything; result_o keeps its last value.
            state_d = ST_IDLE;
            ready_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ready_d = 1'b0;
                    if (bus.start_i) begin
                        rem_d   = ZERO_W;
                        quo_d   = mag_w(bus.dividend_i, bus.signed_i);
                        dvsr_d  = mag_w(bus.divisor_i, bus.signed_i);
                        qneg_d  = bus.signed_i & (bus.dividend_i[DATA_W-1] ^ bus.divisor_i[DATA_W-1]);
                        rneg_d  = bus.signed_i & bus.dividend_i[DATA_W-1];
                        dz_d    = (bus.divisor_i == ZERO_W);
                        dvnd_d  = bus.dividend_i;
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = ST_BUSY;
`ifdef DIV_ZERO_FAST_EN
                        if (bus.divisor_i == ZERO_W) begin
                            state_d  = ST_DONE;
                            result_d = {bus.dividend_i, ALL_ONES};
                            ready_d  = 1'b1;
                        end else begin
                            state_d  = ST_BUSY;
                        end
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    rem_d = step_rem_s;
                    quo_d = step_quo_s;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) begin
                        state_d  = ST_DONE;
                        result_d = fix_result(step_rem_s, step_quo_s, qneg_q, rneg_q, dz_q, dvnd_q);
                        ready_d  = 1'b1;
                    end else begin
                        state_d  = ST_BUSY;
                    end
                end
                ST_DONE: begin
                    // Stay here while start_i is held so a held request never relaunches.
                    if (bus.start_i) begin
                        state_d = ST_DONE;
                        ready_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        ready_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    ready_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d == ST_BUSY);
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            rem_q    <= ZERO_W;
            quo_q    <= ZERO_W;
            dvsr_q   <= ZERO_W;
            dvnd_q   <= ZERO_W;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            result_q <= {(2*DATA_W){1'b0}};
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            dvnd_q   <= dvnd_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;
    assign bus.busy_o   = busy_q;

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed cases plus randomized divides
// compared against an arithmetic reference model.
module tb_ex_div;

    localparam int W = 32;

`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST_DZ = 1'b1;
`else
    localparam bit FAST_DZ = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    ex_div_if #(.DATA_W(W)) dif ();

    ex_div #(.DATA_W(W), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // RISC-V division semantics from plain integer arithmetic.
    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    // Launch at the current negedge (cycle 0) and check latency, busy span and result.
    task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           input string tag, input bit hold);
        logic [63:0] exp_v;
        int lat, busy_n, exp_lat, exp_busy;
        exp_v    = ref_div(sgn, a, b);
        exp_lat  = (FAST_DZ && b == 32'd0) ? 1 : W + 1;
        exp_busy = (FAST_DZ && b == 32'd0) ? 0 : W;
        dif.signed_i   = sgn;
        dif.dividend_i = a;
        dif.divisor_i  = b;
        dif.start_i    = 1'b1;
        lat = 0;
        busy_n = 0;
        for (int k = 1; k <= W + 8; k++) begin
            @(negedge clk);
            if (dif.busy_o) busy_n++;
            if (dif.ready_o) begin
                lat = k;
                break;
            end
            // Operands must be ignored after the launch cycle.
            dif.dividend_i = $urandom;
            dif.divisor_i  = $urandom;
        end
        check_val({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_val({tag, "_busy"}, 64'(busy_n), 64'(exp_busy));
        check_val({tag, "_res"}, dif.result_o, exp_v);
        if (hold) begin
            for (int h = 0; h < 4; h++) begin
                @(negedge clk);
                check_val({tag, "_hold_rdy"}, 64'(dif.ready_o), 64'd1);
                check_val({tag, "_hold_busy"}, 64'(dif.busy_o), 64'd0);
            end
        end
        dif.start_i = 1'b0;
        @(negedge clk);
        check_val({tag, "_drop_rdy"}, 64'(dif.ready_o), 64'd0);
        check_val({tag, "_keep_res"}, dif.result_o, exp_v);
    endtask

    initial begin
        logic [31:0] a, b;
        bit          sgn;
        int          mode;
        bit          rdy_seen;

        n_tests = 0;
        n_fail  = 0;
        rst_n          = 1'b0;
        dif.start_i    = 1'b0;
        dif.annul_i    = 1'b0;
        dif.signed_i   = 1'b0;
        dif.dividend_i = 32'd0;
        dif.divisor_i  = 32'd0;

        repeat (2) @(negedge clk);
        check_val("rst_rdy", 64'(dif.ready_o), 64'd0);
        check_val("rst_busy", 64'(dif.busy_o), 64'd0);
        check_val("rst_res", dif.result_o, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        run_div(1'b0, 32'd100, 32'd7, "t1_divu", 1'b1);
        check_val("t1_val", dif.result_o, {32'd2, 32'd14});
        run_div(1'b1, 32'hFFFF_FFF9, 32'h2, "t2_div", 1'b0);
        check_val("t2_val", dif.result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "t3_ovf", 1'b0);
        check_val("t3_val", dif.result_o, {32'h0, 32'h8000_0000});
        run_div(1'b1, 32'hFFFF_FFFB, 32'h0, "t4_dz", 1'b0);
        check_val("t4_val", dif.result_o, {32'hFFFF_FFFB, 32'hFFFF_FFFF});

        // Annul in BUSY cycle 10, then relaunch.
        dif.signed_i   = 1'b0;
        dif.dividend_i = 32'd20;
        dif.divisor_i  = 32'd3;
        dif.start_i    = 1'b1;
        rdy_seen = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (dif.ready_o) rdy_seen = 1'b1;
        end
        check_val("t5_busy10", 64'(dif.busy_o), 64'd1);
        dif.annul_i = 1'b1;
        @(negedge clk);
        if (dif.ready_o) rdy_seen = 1'b1;
        check_val("t5_annul_busy", 64'(dif.busy_o), 64'd0);
        dif.annul_i = 1'b0;
        dif.start_i = 1'b0;
        @(negedge clk);
        if (dif.ready_o) rdy_seen = 1'b1;
        check_val("t5_idle_busy", 64'(dif.busy_o), 64'd0);
        check_val("t5_no_rdy", 64'(rdy_seen), 64'd0);
        run_div(1'b0, 32'd20, 32'd3, "t5_relaunch", 1'b0);
        check_val("t5_val", dif.result_o, {32'd2, 32'd6});

        // Asynchronous reset in BUSY cycle 15 clears outputs before the next edge.
        dif.signed_i   = 1'b0;
        dif.dividend_i = 32'd1000;
        dif.divisor_i  = 32'd9;
        dif.start_i    = 1'b1;
        for (int k = 1; k <= 15; k++) @(negedge clk);
        check_val("t6_busy15", 64'(dif.busy_o), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("t6_rst_rdy", 64'(dif.ready_o), 64'd0);
        check_val("t6_rst_busy", 64'(dif.busy_o), 64'd0);
        check_val("t6_rst_res", dif.result_o, 64'd0);
        @(negedge clk);
        dif.start_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("t6_post_rdy", 64'(dif.ready_o), 64'd0);
        check_val("t6_post_res", dif.result_o, 64'd0);

        // Randomized divides against the reference model.
        for (int i = 0; i < 24; i++) begin
            mode = $urandom_range(0, 5);
            sgn  = 1'($urandom_range(0, 1));
            a    = $urandom;
            b    = $urandom;
            case (mode)
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'd0;
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4: begin a = 32'($urandom_range(0, 1000)); b = a + 32'($urandom_range(1, 50)); end
                default: b = b >> $urandom_range(0, 31);
            endcase
            run_div(sgn, a, b, "rnd", 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
